// File: rtl/cc_tag_comparator_nway.sv
// N-way set-associative tag comparator: one-cycle address delay, parallel
// way compare, round-robin victim. Optional counters: CC_TAG_CMP_STATS_EN.
module cc_tag_comparator_nway #(
    parameter int TAG_W    = 17,
    parameter int INDEX_W  = 9,
    parameter int OFFSET_W = 6,
    parameter int WAYS     = 4,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TAG_W-1:0]          tag_i,
    input  logic [INDEX_W-1:0]        index_i,
    input  logic [OFFSET_W-1:0]       offset_i,
    input  logic                      hs_pulse_i,
    input  logic                      stall_i,
    input  logic [WAYS*(TAG_W+1)-1:0] rdata_tag_i,
`ifdef CC_TAG_CMP_STATS_EN
    input  logic                      stat_clr_i,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o,
`endif
    output logic [TAG_W-1:0]          tag_delayed_o,
    output logic [INDEX_W-1:0]        index_delayed_o,
    output logic [OFFSET_W-1:0]       offset_delayed_o,
    output logic                      hit_o,
    output logic                      miss_o,
    output logic [WAYS-1:0]           hit_way_onehot_o,
    output logic [WAY_W-1:0]          hit_way_o,
    output logic [WAY_W-1:0]          victim_way_o,
    output logic                      multi_hit_o
);

    localparam int SLOT_W = TAG_W + 1;

    logic [TAG_W-1:0]    tag_d;
    logic [INDEX_W-1:0]  index_d;
    logic [OFFSET_W-1:0] offset_d;
    logic                pulse_d;
    logic [WAY_W-1:0]    rr_ptr;

    logic [WAYS-1:0]     valid;
    logic [WAYS-1:0]     match;
    logic [WAYS-1:0]     lowest_oh;
    logic                any_match;
    logic                multi_raw;
    logic                all_valid;
    logic [WAY_W-1:0]    match_idx;
    logic [WAY_W-1:0]    invalid_idx;
    logic                accept;

    function automatic logic [WAY_W-1:0] enc_low(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = WAY_W'(w);
        end
        return r;
    endfunction

    // Stage 1: capture the request alongside the tag-RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_d    <= '0;
            index_d  <= '0;
            offset_d <= '0;
            pulse_d  <= 1'b0;
        end else if (!stall_i) begin
            tag_d    <= tag_i;
            index_d  <= index_i;
            offset_d <= offset_i;
            pulse_d  <= hs_pulse_i;
        end
    end

    assign tag_delayed_o    = tag_d;
    assign index_delayed_o  = index_d;
    assign offset_delayed_o = offset_d;

    always_comb begin
        valid = '0;
        match = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid[w] = rdata_tag_i[w*SLOT_W+TAG_W];
            match[w] = valid[w] &&
                       (rdata_tag_i[w*SLOT_W +: TAG_W] == tag_d);
        end
    end

    // Two's-complement trick isolates the lowest matching way.
    assign lowest_oh   = match & (~match + WAYS'(1));
    assign multi_raw   = |(match & (match - WAYS'(1)));
    assign any_match   = |match;
    assign all_valid   = &valid;
    assign match_idx   = enc_low(match);
    assign invalid_idx = enc_low(~valid);

    assign hit_o            = pulse_d & any_match;
    assign miss_o           = pulse_d & ~any_match;
    assign multi_hit_o      = pulse_d & multi_raw;
    assign hit_way_onehot_o = hit_o ? lowest_oh : '0;
    assign hit_way_o        = hit_o ? match_idx : '0;

    always_comb begin
        victim_way_o = '0;
        if (miss_o) victim_way_o = all_valid ? rr_ptr : invalid_idx;
    end

    assign accept = pulse_d & ~stall_i;

    generate
        if (WAYS > 1) begin : g_rr
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (accept && miss_o && all_valid) begin
                    if (rr_ptr == WAY_W'(WAYS - 1)) rr_ptr <= '0;
                    else                            rr_ptr <= rr_ptr + WAY_W'(1);
                end
            end
        end else begin : g_no_rr
            assign rr_ptr = '0;
        end
    endgenerate

`ifdef CC_TAG_CMP_STATS_EN
    // Counters saturate rather than wrap so long runs never read low.
    always_ff @(posedge clk) begin
        if (rst || stat_clr_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (accept) begin
            if (hit_o && hit_cnt_o != 32'hFFFF_FFFF)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss_o && miss_cnt_o != 32'hFFFF_FFFF)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cc_tag_comparator_nway.sv
// Bench for cc_tag_comparator_nway: reference model checked every cycle
// plus directed literal expectations.
module tb_cc_tag_comparator_nway;

    localparam int TAG_W = 17;
    localparam int INDEX_W = 9;
    localparam int OFFSET_W = 6;
    localparam int WAYS = 4;
    localparam int WAY_W = 2;
    localparam int SW = TAG_W + 1;

    logic clk = 1'b0;
    logic rst;
    logic [TAG_W-1:0] tag_i;
    logic [INDEX_W-1:0] index_i;
    logic [OFFSET_W-1:0] offset_i;
    logic hs_pulse_i;
    logic stall_i;
    logic [WAYS*SW-1:0] rdata_tag_i;
    logic [TAG_W-1:0] tag_delayed_o;
    logic [INDEX_W-1:0] index_delayed_o;
    logic [OFFSET_W-1:0] offset_delayed_o;
    logic hit_o, miss_o, multi_hit_o;
    logic [WAYS-1:0] hit_way_onehot_o;
    logic [WAY_W-1:0] hit_way_o, victim_way_o;
`ifdef CC_TAG_CMP_STATS_EN
    logic stat_clr_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    int n_pass = 0;
    int n_total = 0;

    cc_tag_comparator_nway #(
        .TAG_W(TAG_W), .INDEX_W(INDEX_W),
        .OFFSET_W(OFFSET_W), .WAYS(WAYS)
    ) dut (
        .clk(clk), .rst(rst),
        .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i),
        .hs_pulse_i(hs_pulse_i), .stall_i(stall_i),
        .rdata_tag_i(rdata_tag_i),
`ifdef CC_TAG_CMP_STATS_EN
        .stat_clr_i(stat_clr_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
        .tag_delayed_o(tag_delayed_o),
        .index_delayed_o(index_delayed_o),
        .offset_delayed_o(offset_delayed_o),
        .hit_o(hit_o), .miss_o(miss_o),
        .hit_way_onehot_o(hit_way_onehot_o),
        .hit_way_o(hit_way_o),
        .victim_way_o(victim_way_o),
        .multi_hit_o(multi_hit_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model state: what the request pipeline holds.
    logic [TAG_W-1:0] m_tag;
    logic [INDEX_W-1:0] m_idx;
    logic [OFFSET_W-1:0] m_off;
    logic m_pulse;
    int m_rr;
    longint m_hc, m_mc;
    logic e_hit, e_miss, e_allv;

    always @(posedge clk) begin
        if (rst) begin
            m_tag <= '0; m_idx <= '0; m_off <= '0;
            m_pulse <= 1'b0; m_rr <= 0;
            m_hc <= 0; m_mc <= 0;
        end else begin
            if (!stall_i) begin
                m_tag <= tag_i; m_idx <= index_i;
                m_off <= offset_i; m_pulse <= hs_pulse_i;
            end
            if (!stall_i && e_miss && e_allv) m_rr <= (m_rr + 1) % WAYS;
`ifdef CC_TAG_CMP_STATS_EN
            if (stat_clr_i) begin
                m_hc <= 0; m_mc <= 0;
            end else if (!stall_i) begin
                if (e_hit && m_hc < 64'hFFFF_FFFF) m_hc <= m_hc + 1;
                if (e_miss && m_mc < 64'hFFFF_FFFF) m_mc <= m_mc + 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        int nmatch, low, finv;
        logic v, h, m;
        logic [TAG_W-1:0] t;
        nmatch = 0; low = 0; finv = -1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            v = rdata_tag_i[w*SW+TAG_W];
            t = rdata_tag_i[w*SW +: TAG_W];
            if (v && t == m_tag) begin nmatch++; low = w; end
            if (!v) finv = w;
        end
        h = m_pulse && nmatch > 0;
        m = m_pulse && nmatch == 0;
        e_hit <= h; e_miss <= m; e_allv <= (finv < 0);
        chk("m_tag_d", tag_delayed_o, m_tag);
        chk("m_idx_d", index_delayed_o, m_idx);
        chk("m_off_d", offset_delayed_o, m_off);
        chk("m_hit", hit_o, h);
        chk("m_miss", miss_o, m);
        chk("m_onehot", hit_way_onehot_o, h ? (64'd1 << low) : 64'd0);
        chk("m_hitway", hit_way_o, h ? low : 0);
        chk("m_multi", multi_hit_o, m_pulse && nmatch >= 2);
        chk("m_victim", victim_way_o,
            m ? ((finv >= 0) ? finv : m_rr) : 0);
`ifdef CC_TAG_CMP_STATS_EN
        chk("m_hitcnt", hit_cnt_o, m_hc);
        chk("m_misscnt", miss_cnt_o, m_mc);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [TAG_W-1:0] t,
                          input logic [INDEX_W-1:0] ix,
                          input logic [OFFSET_W-1:0] of);
        tag_i = t; index_i = ix; offset_i = of;
        hs_pulse_i = 1'b1;
        step();
        hs_pulse_i = 1'b0;
    endtask

    task automatic set4(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [SW-1:0] c, input logic [SW-1:0] d);
        rdata_tag_i = {d, c, b, a};
    endtask

    int vseq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1; stall_i = 1'b0; hs_pulse_i = 1'b1;
        tag_i = 17'h1ABCD; index_i = 9'h05; offset_i = 6'h3C;
        rdata_tag_i = '0;
`ifdef CC_TAG_CMP_STATS_EN
        stat_clr_i = 1'b0;
`endif
        // Reset with a pulse pending
        step(); step();
        @(negedge clk);
        chk("rst_hit", hit_o, 0);
        chk("rst_miss", miss_o, 0);
        chk("rst_tag", tag_delayed_o, 0);
        chk("rst_multi", multi_hit_o, 0);
        rst = 1'b0; hs_pulse_i = 1'b0;
        step();

        // Single hit in way 2
        lookup(17'h1ABCD, 9'h05, 6'h3C);
        set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
             {1'b1, 17'h1ABCD}, {1'b1, 17'h00003});
        @(negedge clk);
        chk("hit_hit", hit_o, 1);
        chk("hit_miss", miss_o, 0);
        chk("hit_way", hit_way_o, 2);
        chk("hit_oh", hit_way_onehot_o, 4'b0100);
        chk("hit_idx", index_delayed_o, 9'h05);
        chk("hit_off", offset_delayed_o, 6'h3C);

        // Miss, ways 1 and 3 invalid (way 1 holds a stale equal tag)
        lookup(17'h0F0F0, 9'h11, 6'h01);
        set4({1'b1, 17'h00001}, {1'b0, 17'h0F0F0},
             {1'b1, 17'h00002}, {1'b0, 17'h00000});
        @(negedge clk);
        chk("inv_miss", miss_o, 1);
        chk("inv_hit", hit_o, 0);
        chk("inv_victim", victim_way_o, 1);

        // Round-robin over back-to-back all-valid misses
        for (int i = 0; i < 6; i++) begin
            lookup(17'h00010, 9'(i), 6'h00);
            set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
                 {1'b1, 17'h00003}, {1'b1, 17'h00004});
            @(negedge clk);
            chk("rr_victim", victim_way_o, vseq[i]);
        end

        // Multi-hit held through three stalled cycles
        lookup(17'h0AAAA, 9'h1F0, 6'h2A);
        set4({1'b1, 17'h0AAAA}, {1'b1, 17'h00001},
             {1'b0, 17'h0AAAA}, {1'b1, 17'h0AAAA});
        stall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mh_hit", hit_o, 1);
            chk("mh_way", hit_way_o, 0);
            chk("mh_oh", hit_way_onehot_o, 4'b0001);
            chk("mh_multi", multi_hit_o, 1);
            chk("mh_tag", tag_delayed_o, 17'h0AAAA);
            if (c == 1) begin
                tag_i = 17'h11111; hs_pulse_i = 1'b1;
            end
            step();
            hs_pulse_i = 1'b0;
            if (c == 2) stall_i = 1'b0;
        end
        @(negedge clk);
        chk("mh_after_hit", hit_o, 0);
        chk("mh_after_miss", miss_o, 0);
        lookup(17'h00010, 9'h0, 6'h0);
        set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
             {1'b1, 17'h00003}, {1'b1, 17'h00004});
        @(negedge clk);
        chk("mh_rr_victim", victim_way_o, 2);

`ifdef CC_TAG_CMP_STATS_EN
        stat_clr_i = 1'b1;
        step();
        stat_clr_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lookup(17'h1ABCD, 9'h05, 6'h3C);
            set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
                 {1'b1, 17'h1ABCD}, {1'b1, 17'h00003});
        end
        lookup(17'h00010, 9'h0, 6'h0);
        set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
             {1'b1, 17'h00003}, {1'b1, 17'h00004});
        stall_i = 1'b1;
        step(); step();
        stall_i = 1'b0;
        lookup(17'h00020, 9'h0, 6'h0);
        step();
        @(negedge clk);
        chk("st_hits", hit_cnt_o, 3);
        chk("st_misses", miss_cnt_o, 2);
        lookup(17'h1ABCD, 9'h05, 6'h3C);
        set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
             {1'b1, 17'h1ABCD}, {1'b1, 17'h00003});
        stat_clr_i = 1'b1;
        step();
        stat_clr_i = 1'b0;
        @(negedge clk);
        chk("st_clr_hits", hit_cnt_o, 0);
        chk("st_clr_misses", miss_cnt_o, 0);
`endif

        // Reset discards an in-flight lookup and rewinds the pointer
        lookup(17'h1ABCD, 9'h05, 6'h3C);
        set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
             {1'b1, 17'h1ABCD}, {1'b1, 17'h00003});
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_hit", hit_o, 0);
        chk("rst2_miss", miss_o, 0);
        lookup(17'h00010, 9'h0, 6'h0);
        set4({1'b1, 17'h00001}, {1'b1, 17'h00002},
             {1'b1, 17'h00003}, {1'b1, 17'h00004});
        @(negedge clk);
        chk("rst2_victim", victim_way_o, 0);
        step();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cc_tag_comparator_nway.md
Name: cc_tag_comparator_nway

Overview:
- Parametrised successor to the direct-mapped cache tag comparator, for an N-way set-associative cache controller.
- Delays the request address by one cycle to align it with the synchronous tag-RAM read.
- Compares the delayed tag against all ways in parallel and reports hit/miss, the hitting way and a replacement victim way.
- Sits between the request handshake logic and the cache-controller FSM.
- Adds a stall hold, a round-robin victim pointer and multi-hit error detection.

Parameters:
- TAG_W, 17, tag width in bits.
- INDEX_W, 9, set index width.
- OFFSET_W, 6, byte offset width.
- WAYS, 4, associativity; power of two, 1..8.
- WAY_W, $clog2(WAYS) with a minimum of 1, width of way index outputs (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tag_i  in  TAG_W  request tag.
- index_i  in  INDEX_W  request set index.
- offset_i  in  OFFSET_W  request offset.
- hs_pulse_i  in  1  one-cycle request handshake pulse; tag RAM read issued the same cycle.
- stall_i  in  1  downstream not ready; hold stage-2 contents.
- rdata_tag_i  in  WAYS*(TAG_W+1)  tag-RAM read data. Way w occupies bits [w*(TAG_W+1) +: TAG_W+1]; the MSB of each slice is the valid bit.
- tag_delayed_o  out  TAG_W  registered tag.
- index_delayed_o  out  INDEX_W  registered index.
- offset_delayed_o  out  OFFSET_W  registered offset.
- hit_o  out  1  lookup hit.
- miss_o  out  1  lookup miss.
- hit_way_onehot_o  out  WAYS  one-hot hitting way.
- hit_way_o  out  WAY_W  encoded hitting way (lowest index if more than one hits).
- victim_way_o  out  WAY_W  way to fill on miss.
- multi_hit_o  out  1  error: more than one valid way matched.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Delayed tag, index and offset, the delayed pulse and the RR pointer all clear to 0.
  - All outputs read 0 the cycle after reset, including hit_o, miss_o and multi_hit_o.
  - Reset overrides stall_i and hs_pulse_i. A lookup in flight during reset is discarded and produces no hit/miss.
- Stage 1 (registered):
  - If stall_i=0: tag_d, index_d, offset_d and pulse_d load tag_i, index_i, offset_i and hs_pulse_i.
  - If stall_i=1: all stage-1 registers hold. hs_pulse_i asserted during a stall is ignored; the upstream must not pulse while stalled.
- Stage 2 (combinational from stage-1 regs and rdata_tag_i):
  - match[w] = valid[w] && (tag[w] == tag_d).
  - When pulse_d=0: hit_o, miss_o, hit_way_onehot_o, hit_way_o and multi_hit_o are all 0.
  - When pulse_d=1:
    - hit_o = |match and miss_o = ~hit_o; exactly one of the two is high.
    - hit_way_onehot_o = match, except that on multi-hit only the lowest set bit is kept.
    - hit_way_o = encoded lowest matching way.
    - multi_hit_o = 1 when two or more ways match.
- Latency: hit/miss is valid exactly one cycle after hs_pulse_i. Back-to-back pulses give back-to-back results.
- Stall extends the result: while stall_i=1 with pulse_d=1, all stage-2 outputs stay stable. The upstream must hold the tag-RAM read data stable for the duration of the stall.
- Victim selection (output valid only when miss_o=1; otherwise 0):
  - If any way is invalid, the victim is the lowest-index invalid way.
  - Otherwise the victim is rr_ptr.
- rr_ptr:
  - WAY_W-bit counter.
  - Increments, wrapping from WAYS-1 to 0, on an accepted miss (pulse_d=1, stall_i=0, miss_o=1) where all ways are valid.
  - Holds on hits, on misses that select an invalid way, and during stall.
- WAYS=1: hit_way_o, victim_way_o and rr_ptr are constant 0, so the block behaves as the direct-mapped comparator.

Optional Feature:
- Macro CC_TAG_CMP_STATS_EN.
- When defined:
  - Adds inputs stat_clr_i (1 bit) and outputs hit_cnt_o and miss_cnt_o (32 bits each).
  - Each counter increments once per accepted hit or accepted miss, and saturates at 0xFFFFFFFF.
  - stat_clr_i clears both counters synchronously; clear takes priority over an increment in the same cycle.
  - rst also clears both counters.
- When undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
1. Reset: assert rst for 2 cycles while hs_pulse_i=1 -> all outputs 0, rr_ptr=0.
2. Single hit, WAYS=4:
   - Stimulus: tag_i=0x1ABCD, index_i=0x05, offset_i=0x3C; next cycle way2 = {1,0x1ABCD}, other ways valid with different tags.
   - Response: hit_o=1, miss_o=0, hit_way_o=2, hit_way_onehot_o=4'b0100, index_delayed_o=0x05, offset_delayed_o=0x3C.
3. Miss with invalid way: way1 and way3 invalid, no match -> miss_o=1, victim_way_o=1, rr_ptr unchanged.
4. Round-robin wrap: 5 consecutive accepted misses with all ways valid and non-matching -> victim_way_o sequence 0,1,2,3,0; rr_ptr=1 afterwards.
5. Multi-hit and stall:
   - Ways 0 and 3 both {1,tag}: hit_o=1, hit_way_o=0, hit_way_onehot_o=4'b0001, multi_hit_o=1.
   - Then hold stall_i=1 for 3 cycles: outputs stay stable, rr_ptr unchanged, a new hs_pulse_i is ignored.
6. Stats (with CC_TAG_CMP_STATS_EN): 3 hits and 2 misses, with one miss issued under stall for 2 cycles -> hit_cnt_o=3, miss_cnt_o=2. Then stat_clr_i=1 in the same cycle as an accepted hit -> both counters read 0.
